dmem_lsu: RTL and testbench

- Load/store unit in the MEM stage; the initiator side of the word-indexed data memory.
- Converts pipeline byte-address requests (byte/half/word, signed/unsigned) into DMEM word accesses with combinational read data and a posedge write.
- The DMEM has no byte enables, so sub-word stores are done as a two-cycle read-modify-write.
- Registers the load result and reports misaligned or out-of-range requests.

---
 rtl/dmem_lsu_if.sv | 31 +++
 rtl/dmem_lsu.sv | 107 ++++++++++
 tb/tb_dmem_lsu.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_lsu_if.sv
// Bundle between the MEM-stage pipeline, the load/store unit and the word-indexed data memory.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dmem_ena;
  logic        dmem_w_ena;
  logic        dmem_r_ena;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_w;
  logic [31:0] dmem_data_r;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dmem_data_r,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dmem_ena, dmem_w_ena, dmem_r_ena, dmem_addr, dmem_data_w
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, dmem_data_r,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dmem_ena, dmem_w_ena, dmem_r_ena, dmem_addr, dmem_data_w
  );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: byte-addressed requests onto a word DMEM without byte enables;
// sub-word stores are a two-cycle read-modify-write through the MERGE state.
module dmem_lsu #(
  parameter int unsigned ADDR_W = 10
) (
  input logic      clk,
  input logic      rst_n,
  dmem_lsu_if.slave bus
);

  typedef enum logic {IDLE, MERGE} state_t;

  state_t            state_q;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-1:0] idx_q, idx;
  logic              resp_valid_q, resp_err_q;
  logic [31:0]       resp_rdata_q, load_d, mask;
  logic [15:0]       lane;
  logic [4:0]        sh;
  logic              err, accept, is_word, sub_store;

  always_comb begin
    idx       = bus.req_addr[ADDR_W+1:2];
    sh        = {bus.req_addr[1:0], 3'b000};
    err       = (bus.req_size == 2'b11)
             || (bus.req_size == 2'b01 && bus.req_addr[0])
             || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
             || ((bus.req_addr >> (ADDR_W + 2)) != '0);
    accept    = bus.req_valid && (state_q == IDLE);
    is_word   = (bus.req_size == 2'b10);
    sub_store = bus.req_we && !is_word;
    // Half lanes are 2-byte aligned once errors are excluded, so the byte shift serves both sizes.
    lane      = 16'(bus.dmem_data_r >> sh);
    case (bus.req_size)
      2'b00:   load_d = bus.req_unsigned ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_d = bus.req_unsigned ? {16'h0, lane} : {{16{lane[15]}}, lane};
      default: load_d = bus.dmem_data_r;
    endcase
    mask    = ((bus.req_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_d = (bus.dmem_data_r & ~mask) | ((bus.req_wdata << sh) & mask);
  end

  always_comb begin
    bus.req_ready   = (state_q == IDLE);
    bus.resp_valid  = resp_valid_q;
    bus.resp_rdata  = resp_rdata_q;
    bus.resp_err    = resp_err_q;
    bus.dmem_ena    = 1'b0;
    bus.dmem_w_ena  = 1'b0;
    bus.dmem_r_ena  = 1'b0;
    bus.dmem_addr   = '0;
    bus.dmem_data_w = '0;
    if (state_q == MERGE) begin
      bus.dmem_ena    = 1'b1;
      bus.dmem_w_ena  = 1'b1;
      bus.dmem_addr   = 32'(idx_q);
      bus.dmem_data_w = merge_q;
    end else if (accept && !err) begin
      bus.dmem_ena  = 1'b1;
      bus.dmem_addr = 32'(idx);
      if (bus.req_we && is_word) begin
        bus.dmem_w_ena  = 1'b1;
        bus.dmem_data_w = bus.req_wdata;
      end else begin
        bus.dmem_r_ena = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (sub_store) begin
              state_q <= MERGE;
              merge_q <= merge_d;
              idx_q   <= idx;
            end else begin
              resp_valid_q <= 1'b1;
              if (!bus.req_we) resp_rdata_q <= load_d;
            end
          end
        end
        MERGE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus a random request stream scored against a byte-lane memory model.
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst_n;

  dmem_lsu_if bus ();
  dmem_lsu #(.ADDR_W(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Data memory seen by the DUT; preloaded through a side port.
  logic [31:0] mem [0:1023];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_a  = '0;
  logic [31:0] pl_d  = '0;
  assign bus.dmem_data_r = mem[bus.dmem_addr[9:0]];
  always @(posedge clk) begin
    if (bus.dmem_ena && bus.dmem_w_ena) mem[bus.dmem_addr[9:0]] <= bus.dmem_data_w;
    else if (pl_we) mem[pl_a] <= pl_d;
  end

  bit [31:0] ref_mem [0:1023];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    bit v; bit we; bit [1:0] size; bit uns; bit [31:0] addr; bit [31:0] wdata;
    bit kat_en; bit [31:0] kat;
  } req_t;
  typedef struct {
    int due; bit err; bit [31:0] rdata; bit kat_en; bit [31:0] kat;
  } rsp_t;

  req_t rq[$];
  rsp_t eq[$];
  int   acc_cyc[$];

  function automatic bit exp_err(bit [1:0] sz, bit [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic bit [31:0] model_load(bit [31:0] w, bit [31:0] a, bit [1:0] sz, bit uns);
    longint unsigned nbits, v;
    nbits = 64'd8 << sz;
    v = ({32'h0, w} >> (8 * (a % 4))) % (64'd1 << nbits);
    if (!uns && nbits < 32 && v >= (64'd1 << (nbits - 1)))
      v = v + (64'd1 << 32) - (64'd1 << nbits);
    return v[31:0];
  endfunction

  function automatic bit [31:0] model_merge(bit [31:0] w, bit [31:0] a, bit [1:0] sz, bit [31:0] wd);
    longint unsigned nbits, shamt, lanev, newv, r;
    nbits = 64'd8 << sz;
    shamt = 8 * (a % 4);
    lanev = ({32'h0, w} >> shamt) % (64'd1 << nbits);
    newv  = {32'h0, wd} % (64'd1 << nbits);
    r = {32'h0, w} - (lanev << shamt) + (newv << shamt);
    return r[31:0];
  endfunction

  task automatic push_req(input bit we, input bit [1:0] size, input bit uns, input bit [31:0] addr,
                          input bit [31:0] wdata, input bit kat_en, input bit [31:0] kat);
    req_t r;
    r.v = 1'b1; r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    r.kat_en = kat_en; r.kat = kat;
    rq.push_back(r);
  endtask

  task automatic push_bubble();
    req_t r;
    r = '{default: '0};
    rq.push_back(r);
  endtask

  task automatic poke(input int unsigned a, input bit [31:0] d);
    pl_we = 1'b1; pl_a = a[9:0]; pl_d = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Drives queued requests with req_valid held, scoring DMEM controls and response timing.
  task automatic run_stream(input int budget);
    int        cyc = 0;
    bit [31:0] m_word = '0;
    bit [9:0]  m_idx = '0;
    req_t      r;
    rsp_t      e;
    bit        due_now, er;
    bit [9:0]  i;
    acc_cyc.delete();
    while ((rq.size() != 0 || eq.size() != 0) && cyc < budget) begin
      due_now = (eq.size() != 0) && (eq[0].due == cyc);
      check("resp_valid", bus.resp_valid, due_now);
      if (due_now) begin
        e = eq.pop_front();
        check("resp_err", bus.resp_err, e.err);
        check("resp_rdata", bus.resp_rdata, e.rdata);
        if (e.kat_en) check("resp_known", bus.resp_rdata, e.kat);
      end
      if (rq.size() != 0 && rq[0].v) begin
        r = rq[0];
        bus.req_we = r.we; bus.req_size = r.size; bus.req_unsigned = r.uns;
        bus.req_addr = r.addr; bus.req_wdata = r.wdata; bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
        if (rq.size() != 0) void'(rq.pop_front());
      end
      #1;
      if (!bus.req_ready) begin
        check("merge_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b110);
        check("merge_addr", bus.dmem_addr, {22'h0, m_idx});
        check("merge_data", bus.dmem_data_w, m_word);
      end else if (bus.req_valid) begin
        er = exp_err(r.size, r.addr);
        i  = r.addr[11:2];
        e.due = cyc + 1; e.err = er; e.rdata = '0; e.kat_en = r.kat_en; e.kat = r.kat;
        if (er) begin
          check("err_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b000);
        end else begin
          check("acc_addr", bus.dmem_addr, r.addr >> 2);
          if (r.we && r.size == 2'b10) begin
            check("sw_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b110);
            check("sw_data", bus.dmem_data_w, r.wdata);
            ref_mem[i] = r.wdata;
          end else begin
            check("rd_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b101);
            if (!r.we) begin
              e.rdata = model_load(ref_mem[i], r.addr, r.size, r.uns);
            end else begin
              m_word = model_merge(ref_mem[i], r.addr, r.size, r.wdata);
              m_idx  = i;
              ref_mem[i] = m_word;
              e.due = cyc + 2;
            end
          end
        end
        eq.push_back(e);
        acc_cyc.push_back(cyc);
        void'(rq.pop_front());
      end else begin
        check("idle_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b000);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.req_valid = 1'b0;
    check("drain", rq.size() + eq.size(), 0);
    rq.delete();
    eq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_acc[4] = '{0, 1, 2, 4};
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    #1;
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_ena", bus.dmem_ena, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int unsigned w = 0; w < 16; w++) poke(w, $urandom);
    poke(5, 32'h1234_5678);
    poke(2, 32'h80FF_7F80);
    poke(3, 32'hAABB_CCDD);
    poke(4, 32'h1122_3344);

    push_req(1'b0, 2'b10, 1'b0, 32'h14, '0, 1'b1, 32'h1234_5678);
    run_stream(10);

    push_req(1'b0, 2'b00, 1'b0, 32'h08, '0, 1'b1, 32'hFFFF_FF80);
    push_req(1'b0, 2'b00, 1'b1, 32'h08, '0, 1'b1, 32'h0000_0080);
    push_req(1'b0, 2'b00, 1'b0, 32'h09, '0, 1'b1, 32'h0000_007F);
    push_req(1'b0, 2'b01, 1'b0, 32'h0A, '0, 1'b1, 32'hFFFF_80FF);
    push_req(1'b0, 2'b01, 1'b1, 32'h0A, '0, 1'b1, 32'h0000_80FF);
    run_stream(20);

    push_req(1'b1, 2'b00, 1'b0, 32'h0E, 32'h0000_0011, 1'b1, 32'h0);
    run_stream(10);
    check("sb_mem", mem[3], 32'hAA11_CCDD);

    push_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h5555, 1'b1, 32'h0);
    push_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, '0, 1'b1, 32'h0);
    push_req(1'b0, 2'b11, 1'b0, 32'h20, '0, 1'b1, 32'h0);
    run_stream(20);

    // Reset during MERGE must abandon the write.
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_00EE; bus.req_valid = 1'b1;
    #1;
    check("rm_rd_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b101);
    check("rm_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rm_merge_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b110);
    check("rm_merge_data", bus.dmem_data_w, 32'h1122_33EE);
    rst_n = 1'b0;
    #1;
    check("rm_rst_ctl", {bus.dmem_ena, bus.dmem_w_ena, bus.dmem_r_ena}, 3'b000);
    check("rm_rst_valid", bus.resp_valid, 1'b0);
    check("rm_rst_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    check("rm_mem", mem[4], 32'h1122_3344);
    check("rm_rst_valid2", bus.resp_valid, 1'b0);
    check("rm_rst_rdata", bus.resp_rdata, 32'h0);
    rst_n = 1'b1;

    push_req(1'b0, 2'b10, 1'b0, 32'h14, '0, 1'b0, '0);
    push_req(1'b1, 2'b10, 1'b0, 32'h24, $urandom, 1'b0, '0);
    push_req(1'b1, 2'b01, 1'b0, 32'h0A, $urandom, 1'b0, '0);
    push_req(1'b0, 2'b10, 1'b0, 32'h08, '0, 1'b0, '0);
    run_stream(20);
    check("tp_accepts", acc_cyc.size(), 4);
    if (acc_cyc.size() == 4)
      for (int k = 0; k < 4; k++) check("tp_accept_cycle", acc_cyc[k], exp_acc[k]);

    for (int n = 0; n < 250; n++) begin
      bit [31:0] a;
      if ($urandom_range(0, 9) == 0) begin
        push_bubble();
      end else begin
        a = ($urandom_range(0, 11) == 0) ? (32'h1000 + $urandom_range(0, 255)) : $urandom_range(0, 63);
        push_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 a, $urandom, 1'b0, '0);
      end
    end
    run_stream(2000);

    for (int unsigned w = 0; w < 16; w++) check("final_mem", mem[w], ref_mem[w]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
